// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - streams chunks into instruction RAM words and holds the core in reset meanwhile
// Optional CHECKSUM_EN adds a running sum of every written word on the CHECKSUM port.
module prog_loader #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32,
   parameter int IN_WIDTH   = 8,
   parameter int BASE_ADDR  = 0
) (
   input  logic                  CLK,
   input  logic                  RESET_N,
   input  logic                  START,
   input  logic [ADDR_WIDTH:0]   LENGTH,
   input  logic [IN_WIDTH-1:0]   IN_DATA,
   input  logic                  IN_VALID,
   output logic                  IN_READY,
   output logic [ADDR_WIDTH-1:0] ADDR_W,
   output logic [DATA_WIDTH-1:0] Q_W,
   output logic                  ENABLE_W,
   output logic                  CORE_RESET_N,
   output logic                  BUSY,
   output logic                  DONE,
   output logic                  ERROR
`ifdef CHECKSUM_EN
   ,
   output logic [DATA_WIDTH-1:0] CHECKSUM
`endif
);

   localparam int CHUNKS = DATA_WIDTH / IN_WIDTH;
   localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
   localparam logic [ADDR_WIDTH+1:0] MEM_WORDS = {1'b0, 1'b1, {ADDR_WIDTH{1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WRITE, S_RUN} state_t;

   state_t                state, state_n;
   logic [CW-1:0]         chunk_cnt;
   logic [ADDR_WIDTH:0]   word_cnt;
   logic [ADDR_WIDTH:0]   len_q;
   logic [DATA_WIDTH-1:0] word_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  done_q;
   logic                  err_q;
`ifdef CHECKSUM_EN
   logic [DATA_WIDTH-1:0] sum_q;
`endif

   logic                  start_seen;
   logic                  len_zero;
   logic                  len_bad;
   logic                  start_ok;
   logic                  hs;
   logic                  last_chunk;
   logic [ADDR_WIDTH+1:0] len_end;
   logic [ADDR_WIDTH:0]   word_inc;

   // START only counts while the core is idle or running, never mid-load
   assign start_seen = START && (state == S_IDLE || state == S_RUN);
   assign len_zero   = (LENGTH == '0);
   assign len_end    = (ADDR_WIDTH+2)'(BASE_ADDR) + {1'b0, LENGTH};
   assign len_bad    = (len_end > MEM_WORDS);
   assign start_ok   = start_seen && !len_bad;
   assign hs         = IN_VALID && (state == S_LOAD);
   assign last_chunk = hs && (chunk_cnt == CW'(CHUNKS-1));
   assign word_inc   = word_cnt + 1'b1;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) state <= S_IDLE;
      else          state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         S_IDLE, S_RUN: if (start_ok) state_n = len_zero ? S_RUN : S_LOAD;
         S_LOAD:        if (last_chunk) state_n = S_WRITE;
         S_WRITE:       state_n = (word_inc < len_q) ? S_LOAD : S_RUN;
         default:       state_n = S_IDLE;
      endcase
   end

   always_comb begin
      IN_READY     = (state == S_LOAD);
      ENABLE_W     = (state == S_WRITE);
      BUSY         = (state == S_LOAD) || (state == S_WRITE);
      CORE_RESET_N = (state == S_RUN);
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         chunk_cnt <= '0;
         word_cnt  <= '0;
         len_q     <= '0;
         word_q    <= '0;
         addr_q    <= ADDR_WIDTH'(BASE_ADDR);
         done_q    <= 1'b0;
         err_q     <= 1'b0;
`ifdef CHECKSUM_EN
         sum_q     <= '0;
`endif
      end else begin
         // a zero-length START issued from RUN is a fresh completion too
         done_q <= (state_n == S_RUN) && ((state != S_RUN) || (start_ok && len_zero));
         if (start_seen) begin
            if (len_bad) begin
               err_q <= 1'b1;
            end else begin
               err_q    <= 1'b0;
               len_q    <= LENGTH;
               word_cnt <= '0;
`ifdef CHECKSUM_EN
               sum_q    <= '0;
`endif
            end
         end
         if (hs) begin
            for (int k = 0; k < CHUNKS; k++) begin
               if (chunk_cnt == CW'(k)) word_q[k*IN_WIDTH +: IN_WIDTH] <= IN_DATA;
            end
            chunk_cnt <= chunk_cnt + 1'b1;
            if (last_chunk) addr_q <= ADDR_WIDTH'(BASE_ADDR) + word_cnt[ADDR_WIDTH-1:0];
         end
         if (state == S_WRITE) begin
            word_cnt  <= word_inc;
            chunk_cnt <= '0;
`ifdef CHECKSUM_EN
            sum_q     <= sum_q + word_q;
`endif
         end
      end
   end

   assign ADDR_W = addr_q;
   assign Q_W    = word_q;
   assign DONE   = done_q;
   assign ERROR  = err_q;
`ifdef CHECKSUM_EN
   assign CHECKSUM = sum_q;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - randomized self-checking bench for prog_loader against a write-list model
module tb_prog_loader;

   localparam int AW   = 10;
   localparam int DW   = 32;
   localparam int IW   = 8;
   localparam int BASE = 0;

   logic          CLK = 1'b0;
   logic          RESET_N;
   logic          START;
   logic [AW:0]   LENGTH;
   logic [IW-1:0] IN_DATA;
   logic          IN_VALID;
   logic          IN_READY;
   logic [AW-1:0] ADDR_W;
   logic [DW-1:0] Q_W;
   logic          ENABLE_W;
   logic          CORE_RESET_N;
   logic          BUSY;
   logic          DONE;
   logic          ERROR;
`ifdef CHECKSUM_EN
   logic [DW-1:0] CHECKSUM;
`endif

   always #5 CLK = ~CLK;

   prog_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .IN_WIDTH(IW), .BASE_ADDR(BASE)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .START(START), .LENGTH(LENGTH),
      .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
      .ADDR_W(ADDR_W), .Q_W(Q_W), .ENABLE_W(ENABLE_W), .CORE_RESET_N(CORE_RESET_N),
      .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR)
`ifdef CHECKSUM_EN
      , .CHECKSUM(CHECKSUM)
`endif
   );

   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } wr_t;

   int          n_cmp    = 0;
   int          n_fail   = 0;
   int          n_writes = 0;
   wr_t         exp_q[$];
   logic [7:0]  load_bytes[$];
   logic [31:0] model_sum;
   wr_t         cmp_e;
   bit          toggle = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // every RAM write must be the next entry of the expected write list
   always @(negedge CLK) begin
      if (RESET_N === 1'b1 && ENABLE_W === 1'b1) begin
         n_writes++;
         if (exp_q.size() == 0) begin
            chk("unexpected_write", 1, 0);
         end else begin
            cmp_e = exp_q.pop_front();
            chk("wr_addr", ADDR_W, cmp_e.a);
            chk("wr_data", Q_W, cmp_e.d);
            chk("ready_low_in_write", IN_READY, 0);
            chk("core_reset_in_write", CORE_RESET_N, 0);
         end
      end
   end

   task automatic do_reset();
      @(negedge CLK);
      RESET_N  = 1'b0;
      START    = 1'b0;
      IN_VALID = 1'b0;
      repeat (3) @(negedge CLK);
      RESET_N = 1'b1;
      exp_q.delete();
   endtask

   task automatic pulse_start(input int len);
      @(negedge CLK);
      START  = 1'b1;
      LENGTH = (AW+1)'(len);
      @(negedge CLK);
      START = 1'b0;
   endtask

   // mode 0: always valid, 1: valid toggles each cycle, 2: random valid
   task automatic send_chunk(input logic [7:0] b, input int mode);
      bit v, rdy, ok;
      ok = 1'b0;
      for (int c = 0; c < 1000; c++) begin
         @(negedge CLK);
         toggle = ~toggle;
         v = (mode == 0) ? 1'b1 : (mode == 1) ? toggle : 1'($urandom_range(0, 1));
         IN_VALID = v;
         IN_DATA  = b;
         rdy      = IN_READY;
         @(posedge CLK);
         if (v && rdy) begin
            ok = 1'b1;
            break;
         end
      end
      #1 IN_VALID = 1'b0;
      if (!ok) chk("chunk_accept_timeout", 0, 1);
   endtask

   task automatic wait_done();
      bit seen;
      seen = 1'b0;
      #1;
      for (int c = 0; c < 2000; c++) begin
         if (DONE) begin
            seen = 1'b1;
            break;
         end
         @(negedge CLK);
      end
      chk("done_seen", seen, 1);
      @(negedge CLK);
      chk("done_one_cycle", DONE, 0);
   endtask

   task automatic run_load(input int len, input int mode, input bit inject, input bit pin);
      logic [31:0] w;
      logic [7:0]  b;
      int          w0;
      w0        = n_writes;
      model_sum = '0;
      pulse_start(len);
      if (len != 0) chk("core_reset_low_on_load", CORE_RESET_N, 0);
      for (int i = 0; i < len; i++) begin
         w = '0;
         for (int k = 0; k < 4; k++) begin
            b = load_bytes.pop_front();
            w = w | (32'(b) << (8 * k));
            send_chunk(b, mode);
         end
         exp_q.push_back('{a: AW'(BASE + i), d: w});
         model_sum = model_sum + w;
         if (pin && i == 0) begin
            chk("pin_model_word0", w, 32'h00500013);
            chk("first_write_en", ENABLE_W, 1);
            chk("first_write_addr", ADDR_W, 0);
            chk("first_write_data", Q_W, 32'h00500013);
         end
         if (inject && i < len - 1) pulse_start(0);
      end
      wait_done();
      chk("write_count", n_writes - w0, len);
      chk("writes_pending", exp_q.size(), 0);
      chk("core_running", CORE_RESET_N, 1);
      chk("busy_after_load", BUSY, 0);
      chk("error_after_load", ERROR, 0);
`ifdef CHECKSUM_EN
      chk("checksum_model", CHECKSUM, model_sum);
`endif
   endtask

   task automatic add_random_bytes(input int n);
      for (int i = 0; i < n; i++) load_bytes.push_back(8'($urandom));
   endtask

   initial begin
      int len, w0;
      logic [7:0] b;
      RESET_N  = 1'b0;
      START    = 1'b0;
      LENGTH   = '0;
      IN_DATA  = '0;
      IN_VALID = 1'b0;
      model_sum = '0;
      do_reset();

      // idle with junk on the stream: nothing acknowledged, nothing written
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         IN_VALID = 1'b1;
         IN_DATA  = 8'($urandom);
      end
      @(negedge CLK);
      chk("rst_core_reset_n", CORE_RESET_N, 0);
      chk("rst_in_ready", IN_READY, 0);
      chk("rst_enable_w", ENABLE_W, 0);
      chk("rst_error", ERROR, 0);
      chk("rst_busy", BUSY, 0);
      chk("rst_done", DONE, 0);
      chk("rst_addr_w", ADDR_W, BASE);
      chk("rst_q_w", Q_W, 0);
      chk("rst_no_writes", n_writes, 0);
      IN_VALID = 1'b0;

      // first word 13,00,50,00 then two more; completion and DONE
      load_bytes.delete();
      load_bytes.push_back(8'h13);
      load_bytes.push_back(8'h00);
      load_bytes.push_back(8'h50);
      load_bytes.push_back(8'h00);
      add_random_bytes(8);
      run_load(3, 0, 1'b0, 1'b1);

      // reload from RUN with a toggling stream and an ignored START mid-load
      add_random_bytes(12);
      run_load(3, 1, 1'b1, 1'b0);

      // bad length while running keeps the core running
      pulse_start(1025);
      #1;
      chk("run_bad_error", ERROR, 1);
      chk("run_bad_core_running", CORE_RESET_N, 1);
      chk("run_bad_busy", BUSY, 0);

      // bad length from IDLE, then zero length clears ERROR
      do_reset();
      w0 = n_writes;
      pulse_start(1025);
      #1;
      chk("bad_error", ERROR, 1);
      chk("bad_busy", BUSY, 0);
      chk("bad_core_reset", CORE_RESET_N, 0);
      repeat (3) @(negedge CLK);
      chk("bad_no_write", n_writes - w0, 0);
      run_load(0, 0, 1'b0, 1'b0);
      chk("zero_no_write", n_writes - w0, 0);

      // full memory: last address 2**AW-1
      add_random_bytes(4 * 1024);
      run_load(1024, 0, 1'b0, 1'b0);
      chk("full_last_addr", ADDR_W, 1023);

      // reset in the middle of word 1
      do_reset();
      w0 = n_writes;
      add_random_bytes(6);
      pulse_start(4);
      begin
         logic [31:0] w;
         w = '0;
         for (int k = 0; k < 4; k++) begin
            b = load_bytes.pop_front();
            w = w | (32'(b) << (8 * k));
            send_chunk(b, 2);
         end
         exp_q.push_back('{a: AW'(BASE), d: w});
      end
      for (int k = 0; k < 2; k++) send_chunk(load_bytes.pop_front(), 0);
      #2 RESET_N = 1'b0;
      #1;
      chk("midrst_in_ready", IN_READY, 0);
      chk("midrst_enable_w", ENABLE_W, 0);
      chk("midrst_busy", BUSY, 0);
      chk("midrst_writes", n_writes - w0, 1);
      chk("midrst_pending", exp_q.size(), 0);
      repeat (3) @(negedge CLK);
      RESET_N = 1'b1;
      repeat (4) @(negedge CLK);
      chk("midrst_no_more_writes", n_writes - w0, 1);
      add_random_bytes(4);
      run_load(1, 0, 1'b0, 1'b0);

`ifdef CHECKSUM_EN
      load_bytes.delete();
      for (int i = 0; i < 4; i++) load_bytes.push_back(i == 0 ? 8'h01 : 8'h00);
      for (int i = 0; i < 4; i++) load_bytes.push_back(i == 0 ? 8'h02 : 8'h00);
      for (int i = 0; i < 4; i++) load_bytes.push_back(8'hFF);
      run_load(3, 0, 1'b0, 1'b0);
      chk("checksum_literal", CHECKSUM, 2);
`endif

      // randomized loads
      for (int r = 0; r < 10; r++) begin
         len = $urandom_range(1, 6);
         add_random_bytes(4 * len);
         run_load(len, $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL global_timeout: simulation did not finish, n_fail=%0d", n_fail);
      $fatal(1);
   end

endmodule
